// File: rtl/ahb_decoder_1m3s_pkg.sv
// ahb_decoder_1m3s_pkg
// Shared types for the 1-master / 3-slave AHB-Lite decoder:
//   - one-hot data-phase owner encodings (dsel)
//   - default-slave FSM states
//   - HTRANS / HRESP codes
//   - address match helper
package ahb_decoder_1m3s_pkg;

    typedef logic [4:0] dsel_t;

    localparam dsel_t DSEL_S0   = 5'b00001;
    localparam dsel_t DSEL_S1   = 5'b00010;
    localparam dsel_t DSEL_S2   = 5'b00100;
    localparam dsel_t DSEL_DEF  = 5'b01000;
    localparam dsel_t DSEL_NONE = 5'b10000;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    function automatic logic addr_match(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/ahb_decoder_1m3s_if.sv
// ahb_decoder_1m3s_if
// Master-side AHB-Lite bus between an upstream master (or arbiter mux)
// and the decoder.
//   master modport : drives address/control/write data, receives response
//   slave modport  : the decoder's view
interface ahb_decoder_1m3s_if #(
    parameter int SZ = 64
);
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [SZ-1:0] HWDATA;
    logic          HREADY;
    logic [SZ-1:0] HRDATA;
    logic          HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HREADY, HRDATA, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HREADY, HRDATA, HRESP
    );
endinterface

// File: rtl/ahb_decoder_1m3s_default_slave.sv
// ahb_default_slave
// Default slave for unmapped transfers: answers every active transfer it
// owns with a two-cycle ERROR response.
//   HCLK, HRESETn : clock, async active-low reset
//   hready_i      : bus HREADY as seen by the master (address phase accept)
//   def_sel_i     : active transfer to an unmapped address
//   hready_o      : default slave HREADYOUT
//   hresp_o       : default slave HRESP
//
// state   | meaning
// DS_IDLE | not owning a data phase
// DS_ERR1 | first ERROR cycle, stall (HREADY=0, HRESP=1)
// DS_ERR2 | second ERROR cycle, complete (HREADY=1, HRESP=1)
module ahb_default_slave
    import ahb_decoder_1m3s_pkg::*;
(
    input  logic HCLK,
    input  logic HRESETn,
    input  logic hready_i,
    input  logic def_sel_i,
    output logic hready_o,
    output logic hresp_o
);

    ds_state_e state_q, state_d;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= DS_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        hready_o = 1'b1;
        hresp_o  = HRESP_OKAY;
        case (state_q)
            DS_IDLE: begin
                if (hready_i && def_sel_i) state_d = DS_ERR1;
            end
            DS_ERR1: begin
                hready_o = 1'b0;
                hresp_o  = HRESP_ERROR;
                state_d  = DS_ERR2;
            end
            DS_ERR2: begin
                hresp_o = HRESP_ERROR;
                // HREADY is high here, so a pipelined unmapped transfer
                // starts its own error response straight away.
                state_d = def_sel_i ? DS_ERR1 : DS_IDLE;
            end
            default: state_d = DS_IDLE;
        endcase
    end

endmodule

// File: rtl/ahb_decoder_1m3s.sv
// ahb_decoder_1m3s
// AHB-Lite address decoder and response mux, one master to three slaves
// plus an internal default slave for unmapped addresses.
//   HCLK, HRESETn        : clock, async active-low reset
//   m (slave modport)    : master-side bus (SZ must match the interface)
//   HADDR_S..HWDATA_S    : address/control/write data broadcast to slaves
//   HSEL_S0..HSEL_S2     : slave selects (not qualified by HTRANS)
//   HREADYOUT_Sx, HRDATA_Sx, HRESP_Sx : slave responses
// Master HREADY is also the HREADY input of every slave.
module ahb_decoder_1m3s
    import ahb_decoder_1m3s_pkg::*;
#(
    parameter int          SZ      = 64,
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hF000_0000,
    parameter logic [31:0] S1_BASE = 32'h1000_0000,
    parameter logic [31:0] S1_MASK = 32'hF000_0000,
    parameter logic [31:0] S2_BASE = 32'h4000_0000,
    parameter logic [31:0] S2_MASK = 32'hF000_0000
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    ahb_decoder_1m3s_if.slave   m,
    output logic [31:0]         HADDR_S,
    output logic [1:0]          HTRANS_S,
    output logic                HWRITE_S,
    output logic [2:0]          HSIZE_S,
    output logic [SZ-1:0]       HWDATA_S,
    output logic                HSEL_S0,
    output logic                HSEL_S1,
    output logic                HSEL_S2,
    input  logic                HREADYOUT_S0,
    input  logic                HREADYOUT_S1,
    input  logic                HREADYOUT_S2,
    input  logic [SZ-1:0]       HRDATA_S0,
    input  logic [SZ-1:0]       HRDATA_S1,
    input  logic [SZ-1:0]       HRDATA_S2,
    input  logic                HRESP_S0,
    input  logic                HRESP_S1,
    input  logic                HRESP_S2
);

    logic          match0, match1, match2;
    logic          def_sel;
    logic          hready;
    logic          hresp;
    logic [SZ-1:0] hrdata;
    logic          ds_hready, ds_hresp;
    dsel_t         dsel_q, dsel_d;

    assign HADDR_S  = m.HADDR;
    assign HTRANS_S = m.HTRANS;
    assign HWRITE_S = m.HWRITE;
    assign HSIZE_S  = m.HSIZE;
    assign HWDATA_S = m.HWDATA;

    assign match0 = addr_match(m.HADDR, S0_BASE, S0_MASK);
    assign match1 = addr_match(m.HADDR, S1_BASE, S1_MASK);
    assign match2 = addr_match(m.HADDR, S2_BASE, S2_MASK);

    // Fixed priority keeps the selects one-hot if windows overlap.
    assign HSEL_S0 = match0;
    assign HSEL_S1 = match1 & ~match0;
    assign HSEL_S2 = match2 & ~match0 & ~match1;

    assign def_sel = m.HTRANS[1] & ~(match0 | match1 | match2);

    always_comb begin
        dsel_d = dsel_q;
        if (hready) begin
            if (HSEL_S0)      dsel_d = DSEL_S0;
            else if (HSEL_S1) dsel_d = DSEL_S1;
            else if (HSEL_S2) dsel_d = DSEL_S2;
            else if (def_sel) dsel_d = DSEL_DEF;
            else              dsel_d = DSEL_NONE;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) dsel_q <= DSEL_NONE;
        else          dsel_q <= dsel_d;
    end

    always_comb begin
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        hrdata = '0;
        case (dsel_q)
            DSEL_S0: begin
                hready = HREADYOUT_S0;
                hresp  = HRESP_S0;
                hrdata = HRDATA_S0;
            end
            DSEL_S1: begin
                hready = HREADYOUT_S1;
                hresp  = HRESP_S1;
                hrdata = HRDATA_S1;
            end
            DSEL_S2: begin
                hready = HREADYOUT_S2;
                hresp  = HRESP_S2;
                hrdata = HRDATA_S2;
            end
            DSEL_DEF: begin
                hready = ds_hready;
                hresp  = ds_hresp;
            end
            default: ;
        endcase
    end

    assign m.HREADY = hready;
    assign m.HRESP  = hresp;
    assign m.HRDATA = hrdata;

    ahb_default_slave u_default_slave (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .hready_i  (hready),
        .def_sel_i (def_sel),
        .hready_o  (ds_hready),
        .hresp_o   (ds_hresp)
    );

endmodule

// File: tb/tb_ahb_decoder_1m3s.sv
module tb_ahb_decoder_1m3s;

    localparam int SZ = 64;
    localparam logic [31:0] S0_BASE = 32'h0000_0000, S0_MASK = 32'hF000_0000;
    localparam logic [31:0] S1_BASE = 32'h1000_0000, S1_MASK = 32'hF000_0000;
    localparam logic [31:0] S2_BASE = 32'h4000_0000, S2_MASK = 32'hF000_0000;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_decoder_1m3s_if #(.SZ(SZ)) bus ();

    logic [31:0]   HADDR_S;
    logic [1:0]    HTRANS_S;
    logic          HWRITE_S;
    logic [2:0]    HSIZE_S;
    logic [SZ-1:0] HWDATA_S;
    logic          HSEL_S0, HSEL_S1, HSEL_S2;
    logic          ro [3];
    logic [SZ-1:0] rd [3];
    logic          rr [3];

    ahb_decoder_1m3s #(.SZ(SZ)) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .m            (bus),
        .HADDR_S      (HADDR_S),
        .HTRANS_S     (HTRANS_S),
        .HWRITE_S     (HWRITE_S),
        .HSIZE_S      (HSIZE_S),
        .HWDATA_S     (HWDATA_S),
        .HSEL_S0      (HSEL_S0),
        .HSEL_S1      (HSEL_S1),
        .HSEL_S2      (HSEL_S2),
        .HREADYOUT_S0 (ro[0]),
        .HREADYOUT_S1 (ro[1]),
        .HREADYOUT_S2 (ro[2]),
        .HRDATA_S0    (rd[0]),
        .HRDATA_S1    (rd[1]),
        .HRDATA_S2    (rd[2]),
        .HRESP_S0     (rr[0]),
        .HRESP_S1     (rr[1]),
        .HRESP_S2     (rr[2])
    );

    int checks = 0;
    int errors = 0;

    // Model: who owns the data phase (0..2 slave, 3 default, 4 nobody) and
    // which cycle of the two-cycle error response we are in.
    int   m_owner = 4;
    int   m_err_cyc = 0;
    logic m_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        if ((a & S0_MASK) == S0_BASE) return 0;
        if ((a & S1_MASK) == S1_BASE) return 1;
        if ((a & S2_MASK) == S2_BASE) return 2;
        return 3;
    endfunction

    task automatic compare_all();
        int            s;
        logic          e_resp;
        logic [SZ-1:0] e_data;
        s = decode(bus.HADDR);
        if (m_owner < 3) begin
            m_ready = ro[m_owner];
            e_resp  = rr[m_owner];
            e_data  = rd[m_owner];
        end else if (m_owner == 3) begin
            m_ready = (m_err_cyc == 2);
            e_resp  = 1'b1;
            e_data  = '0;
        end else begin
            m_ready = 1'b1;
            e_resp  = 1'b0;
            e_data  = '0;
        end
        chk("hsel_s0", HSEL_S0, s == 0);
        chk("hsel_s1", HSEL_S1, s == 1);
        chk("hsel_s2", HSEL_S2, s == 2);
        chk("hready",  bus.HREADY, m_ready);
        chk("hresp",   bus.HRESP, e_resp);
        chk("hrdata",  bus.HRDATA, e_data);
        chk("haddr_s", HADDR_S, bus.HADDR);
        chk("ctrl_s",  {HTRANS_S, HWRITE_S, HSIZE_S}, {bus.HTRANS, bus.HWRITE, bus.HSIZE});
        chk("hwdata_s", HWDATA_S, bus.HWDATA);
    endtask

    task automatic model_clock();
        int s;
        s = decode(bus.HADDR);
        if (m_owner == 3 && m_err_cyc == 1) begin
            m_err_cyc = 2;
        end else if (m_ready) begin
            if (s < 3) begin
                m_owner = s;
            end else if (bus.HTRANS[1]) begin
                m_owner = 3;
                m_err_cyc = 1;
            end else begin
                m_owner = 4;
            end
        end
    endtask

    task automatic model_reset();
        m_owner = 4;
        m_err_cyc = 0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cyc();
        #1;
        compare_all();
        @(posedge HCLK);
        if (HRESETn) model_clock();
        @(negedge HCLK);
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic w);
        bus.HADDR  = a;
        bus.HTRANS = t;
        bus.HWRITE = w;
        bus.HSIZE  = 3'd3;
        bus.HWDATA = {$urandom, $urandom};
    endtask

    task automatic slaves(input logic r0, input logic r1, input logic r2);
        ro[0] = r0; ro[1] = r1; ro[2] = r2;
        for (int i = 0; i < 3; i++) begin
            rd[i] = {$urandom, $urandom};
            rr[i] = 1'b0;
        end
    endtask

    task automatic settle();
        #1;
    endtask

    localparam logic [63:0] PAT_A5 = 64'hA5A5_A5A5_A5A5_A5A5;

    initial begin
        logic [31:0] addr_pool [5];
        logic [63:0] d0;

        addr_pool[0] = 32'h0000_0000;
        addr_pool[1] = 32'h1000_0000;
        addr_pool[2] = 32'h4000_0000;
        addr_pool[3] = 32'h8000_0000;
        addr_pool[4] = 32'hC000_0000;

        drive(32'h8000_0000, 2'b00, 1'b0);
        slaves(1'b1, 1'b1, 1'b1);
        repeat (2) @(negedge HCLK);
        settle();
        chk("rst_hready", bus.HREADY, 1'b1);
        chk("rst_hresp",  bus.HRESP, 1'b0);
        chk("rst_hrdata", bus.HRDATA, 64'h0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // 1: idle after reset
        drive(32'h8000_0000, 2'b00, 1'b0);
        repeat (2) cyc();

        // 2: stalled read from S1
        drive(32'h1000_0010, 2'b10, 1'b0);
        slaves(1'b1, 1'b1, 1'b1);
        settle();
        chk("t2_hsel_s1", HSEL_S1, 1'b1);
        cyc();
        drive(32'h0000_0000, 2'b00, 1'b0);
        for (int k = 0; k < 2; k++) begin
            slaves(1'b1, 1'b0, 1'b1);
            settle();
            chk("t2_stall", bus.HREADY, 1'b0);
            cyc();
        end
        slaves(1'b1, 1'b1, 1'b1);
        rd[1] = PAT_A5;
        settle();
        chk("t2_ready", bus.HREADY, 1'b1);
        chk("t2_rdata", bus.HRDATA, PAT_A5);
        chk("t2_resp",  bus.HRESP, 1'b0);
        cyc();

        // 3: write S0 then read S2 back-to-back
        drive(32'h0000_0000, 2'b10, 1'b1);
        slaves(1'b1, 1'b1, 1'b1);
        cyc();
        drive(32'h4000_0004, 2'b10, 1'b0);
        slaves(1'b1, 1'b1, 1'b0);
        d0 = rd[0];
        settle();
        chk("t3_s0_ready", bus.HREADY, 1'b1);
        chk("t3_s0_data",  bus.HRDATA, d0);
        chk("t3_hsel_s2",  HSEL_S2, 1'b1);
        cyc();
        drive(32'h8000_0000, 2'b00, 1'b0);
        slaves(1'b0, 1'b1, 1'b1);
        rd[2] = 64'h1234_5678_9ABC_DEF0;
        settle();
        chk("t3_s2_ready", bus.HREADY, 1'b1);
        chk("t3_s2_data",  bus.HRDATA, 64'h1234_5678_9ABC_DEF0);
        cyc();

        // 4: unmapped NONSEQ -> two-cycle ERROR, then IDLE okay
        drive(32'h8000_0000, 2'b10, 1'b0);
        cyc();
        drive(32'h8000_0000, 2'b00, 1'b0);
        settle();
        chk("t4_c1_ready", bus.HREADY, 1'b0);
        chk("t4_c1_resp",  bus.HRESP, 1'b1);
        cyc();
        settle();
        chk("t4_c2_ready", bus.HREADY, 1'b1);
        chk("t4_c2_resp",  bus.HRESP, 1'b1);
        cyc();
        settle();
        chk("t4_idle_ready", bus.HREADY, 1'b1);
        chk("t4_idle_resp",  bus.HRESP, 1'b0);

        // 5: IDLE to unmapped stays zero-wait OKAY
        cyc();
        settle();
        chk("t5_ready", bus.HREADY, 1'b1);
        chk("t5_resp",  bus.HRESP, 1'b0);
        cyc();

        // 6: reset while S2 stalls
        drive(32'h4000_0000, 2'b10, 1'b0);
        slaves(1'b1, 1'b1, 1'b1);
        cyc();
        drive(32'h8000_0000, 2'b00, 1'b0);
        slaves(1'b1, 1'b1, 1'b0);
        settle();
        chk("t6_stall", bus.HREADY, 1'b0);
        #1 HRESETn = 1'b0;
        #1;
        chk("t6_rst_ready", bus.HREADY, 1'b1);
        chk("t6_rst_resp",  bus.HRESP, 1'b0);
        model_reset();
        @(negedge HCLK);
        cyc();
        HRESETn = 1'b1;
        drive(32'h4000_0008, 2'b10, 1'b0);
        slaves(1'b1, 1'b1, 1'b1);
        cyc();
        drive(32'h8000_0000, 2'b00, 1'b0);
        rd[2] = 64'h0F0F_0000_FFFF_1111;
        settle();
        chk("t6_resume", bus.HRDATA, 64'h0F0F_0000_FFFF_1111);
        cyc();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            a = addr_pool[$urandom_range(0, 4)] | ($urandom & 32'h0FFF_FFFC);
            if ($urandom_range(0, 9) == 0) a = $urandom;
            drive(a, 2'($urandom_range(0, 3)), 1'($urandom));
            slaves($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 3) != 0);
            for (int i = 0; i < 3; i++) rr[i] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 HRESETn = 1'b0;
                model_reset();
                cyc();
                HRESETn = 1'b1;
            end else begin
                cyc();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
